module_multicycle_control: RTL and testbench
============================================

Name: module_multicycle_control

Overview:
- Moore-style FSM controller for a multicycle RV32I datapath. It sequences a shared ALU, the unified instruction/data memory port, the instruction register and the immediate extender over several cycles per instruction.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.
- It drives every mux select, every write enable, the extender's immediate-format select and the ALU operation code.
- Memory accesses stall on a ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the state_o debug port.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous reset, active high
- op_i  in  7  opcode, instr[6:0] from the instruction register
- funct3_i  in  3  instr[14:12]
- funct7b5_i  in  1  instr[30]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC register load enable
- adr_src_o  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write_o  out  1  memory write strobe
- ir_write_o  out  1  instruction register and OldPC load enable
- reg_write_o  out  1  register file write enable
- result_src_o  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a_o  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- alu_src_b_o  out  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4
- imm_src_o  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- alu_control_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_o  out  1  sticky flag: unsupported opcode decoded
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Clocking and reset: single clock domain. rst_i is asynchronous and active high; it forces state=FETCH and illegal_o=0.
- Output values while rst_i=1:
  - all write enables 0
  - adr_src_o=0, alu_src_a_o=00, alu_src_b_o=10, result_src_o=10, alu_control_o=000
  - imm_src_o decoded from op_i as usual
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 return to FETCH on the next edge with all enables 0.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10.
  - ir_write and pc_write are both equal to mem_ready_i.
  - Stay in FETCH while mem_ready_i=0; go to DECODE when mem_ready_i=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, aluop=00 (computes the branch/jump target).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> FETCH and set illegal_o (sticky until reset).
- MEMADR: alu_src_a=10, alu_src_b=01, aluop=00. Next state is MEMREAD if op_i=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait while mem_ready_i=0, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_write=1.
  - mem_write stays high every cycle until mem_ready_i=1, then FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, aluop=10, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, aluop=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, aluop=01, result_src=00.
  - pc_write=zero_i, then FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_write=1 (PC loads the target held in ALUOut).
  - Next state is ALUWB, which writes rd with OldPC+4.
- Default values: any output not listed for a state is 0.
- Immediate select, combinational from op_i, valid in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - everything else -> 00
- ALU decode, combinational:
  - aluop 00 -> add; aluop 01 -> sub.
  - aluop 10 by funct3:
    - 000 -> sub if op_i[5] and funct7b5_i are both 1, otherwise add (so addi with instr[30]=1 stays add)
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other funct3 -> add
- Output timing: every output except illegal_o is combinational from state and the inputs. The next state registers on the rising edge.
- Reset asserted mid-instruction: enables drop immediately (asynchronously); after release the FSM restarts at FETCH.

Test Plan:
- Reset: hold rst_i, then release with mem_ready_i=1 -> state_o=0; all enables 0 during reset; first cycle after release has ir_write_o=1 and pc_write_o=1.
- Load word: op_i=0000011, mem_ready_i=1 -> states 0,1,2,3,4,0. MEMWB has reg_write_o=1 and result_src_o=01. In MEMADR, imm_src_o=00.
- Store with stall: op_i=0100011, mem_ready_i held 0 for 3 cycles in MEMWRITE -> mem_write_o=1 for 4 cycles, adr_src_o=1, imm_src_o=01, then FETCH.
- R-type sub vs addi:
  - op_i=0110011, funct3=000, funct7b5=1 -> alu_control_o=001 in EXECUTER.
  - op_i=0010011, funct7b5=1 -> 000.
  - funct3=111 -> 010.
- Branches:
  - beq with zero_i=1 -> pc_write_o=1 in BEQ with alu_control_o=001.
  - beq with zero_i=0 -> pc_write_o=0.
  - jal -> states 0,1,10,8,0 with imm_src_o=11 and pc_write_o=1 in JAL.
- Illegal opcode: op_i=1111111 -> DECODE goes to FETCH and illegal_o=1; illegal_o stays 1 through later valid instructions until rst_i.

Source files
------------

// File: rtl/module_multicycle_control.sv
// Multicycle RV32I controller: Moore FSM sequencing the shared ALU, unified
// memory port, instruction register and immediate extender.
module module_multicycle_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         op_i,
    input  logic [2:0]         funct3_i,
    input  logic               funct7b5_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               adr_src_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               reg_write_o,
    output logic [1:0]         result_src_o,
    output logic [1:0]         alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         imm_src_o,
    output logic [2:0]         alu_control_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;

    // Next-state and per-state control decode (Moore, plus handshake-qualified enables)
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        alu_op       = 2'b00;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        adr_src_o    = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;

        case (state_q)
            StFetch: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write     = mem_ready_i;
                pc_write     = mem_ready_i;
                if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                // ALU forms OldPC + imm so branch/jump targets are ready in ALUOut
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBeq:           state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (op_i == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                result_src_o = 2'b01;
                reg_write    = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                adr_src_o = 1'b1;
                mem_write = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a_o = 2'b10;
                alu_op      = 2'b10;
                state_d     = StAluWb;
            end
            StExecI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op      = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBeq: begin
                alu_src_a_o = 2'b10;
                alu_op      = 2'b01;
                pc_write    = zero_i;
                state_d     = StFetch;
            end
            StJal: begin
                // PC takes the target from ALUOut while the ALU computes OldPC + 4 for rd
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write    = 1'b1;
                state_d     = StAluWb;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Immediate format depends only on the opcode, valid in every state
    always_comb begin
        case (op_i)
            OpStore: imm_src_o = 2'b01;
            OpBeq:   imm_src_o = 2'b10;
            OpJal:   imm_src_o = 2'b11;
            default: imm_src_o = 2'b00;
        endcase
    end

    // ALU operation decode from aluop and funct fields
    always_comb begin
        alu_control_o = 3'b000;
        case (alu_op)
            2'b01: alu_control_o = 3'b001;
            2'b10: begin
                case (funct3_i)
                    // op_i[5] separates R-type from I-type so addi never becomes sub
                    3'b000:  alu_control_o = (op_i[5] && funct7b5_i) ? 3'b001 : 3'b000;
                    3'b010:  alu_control_o = 3'b101;
                    3'b110:  alu_control_o = 3'b011;
                    3'b111:  alu_control_o = 3'b010;
                    default: alu_control_o = 3'b000;
                endcase
            end
            default: alu_control_o = 3'b000;
        endcase
    end

    // Write enables drop immediately while reset is held
    always_comb begin
        pc_write_o  = pc_write  & ~rst_i;
        ir_write_o  = ir_write  & ~rst_i;
        reg_write_o = reg_write & ~rst_i;
        mem_write_o = mem_write & ~rst_i;
        illegal_o   = illegal_q;
        state_o     = STATE_W'(state_q);
    end

    // State and sticky illegal-opcode flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_module_multicycle_control.sv
// Randomized instruction stream checked against a per-instruction state plan
// and a table of control values for each state.
module tb_module_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
    localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9;
    localparam int S_JAL = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    bit ill_model = 1'b0;

    int st_q[$];
    bit rdy_q[$];

    module_multicycle_control #(.STATE_W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .op_i          (op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .pc_write_o    (pc_write),
        .adr_src_o     (adr_src),
        .mem_write_o   (mem_write),
        .ir_write_o    (ir_write),
        .reg_write_o   (reg_write),
        .result_src_o  (result_src),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .imm_src_o     (imm_src),
        .alu_control_o (alu_control),
        .illegal_o     (illegal),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Expected {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
    // alu_src_a, alu_src_b, imm_src, alu_control} for a state and inputs.
    function automatic logic [15:0] exp_ctrl(input int st, input bit in_rst);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0;
        logic [1:0] rs = 0, a = 0, b = 0, imm = 0, aop = 0;
        logic [2:0] alu;
        case (st)
            S_FETCH:    begin b = 2; rs = 2; irw = mem_ready; pcw = mem_ready; end
            S_DECODE:   begin a = 1; b = 1; end
            S_MEMADR:   begin a = 2; b = 1; end
            S_MEMREAD:  adr = 1;
            S_MEMWB:    begin rs = 1; rw = 1; end
            S_MEMWRITE: begin adr = 1; mw = 1; end
            S_EXECR:    begin a = 2; aop = 2; end
            S_EXECI:    begin a = 2; b = 1; aop = 2; end
            S_ALUWB:    rw = 1;
            S_BEQ:      begin a = 2; aop = 1; pcw = zero; end
            S_JAL:      begin a = 1; b = 2; pcw = 1; end
            default:    ;
        endcase
        if (in_rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
        imm = (op == 7'b0100011) ? 2'd1 : (op == 7'b1100011) ? 2'd2 :
              (op == 7'b1101111) ? 2'd3 : 2'd0;
        if (aop == 1) alu = 3'b001;
        else if (aop == 0) alu = 3'b000;
        else if (funct3 == 3'b000) alu = (op[5] && funct7b5) ? 3'b001 : 3'b000;
        else if (funct3 == 3'b010) alu = 3'b101;
        else if (funct3 == 3'b110) alu = 3'b011;
        else if (funct3 == 3'b111) alu = 3'b010;
        else alu = 3'b000;
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control};
    endfunction

    task automatic check_now(input string tag, input int st, input bit in_rst);
        logic [15:0] e;
        e = exp_ctrl(st, in_rst);
        checks++;
        assert (state === 4'(st)) else begin
            failures++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state, st);
        end
        checks++;
        assert (obs_ctrl() === e) else begin
            failures++;
            $error("FAIL %s ctrl st=%0d op=%b obs=%h exp=%h", tag, st, op, obs_ctrl(), e);
        end
        checks++;
        assert (illegal === ill_model) else begin
            failures++;
            $error("FAIL %s illegal obs=%b exp=%b", tag, illegal, ill_model);
        end
    endtask

    // Entered #1 after a rising edge; drives inputs, checks at the falling edge.
    task automatic step(input int st, input bit rdy);
        mem_ready = rdy;
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_now("step", st, 1'b0);
        if (st == S_DECODE && !is_legal(op)) ill_model = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input int st);
        int n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin st_q.push_back(st); rdy_q.push_back(1'b0); end
        st_q.push_back(st);
        rdy_q.push_back(1'b1);
    endtask

    task automatic push_plain(input int st);
        st_q.push_back(st);
        rdy_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic run_instr(input int cls);
        logic [6:0] o;
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        st_q.delete();
        rdy_q.delete();
        push_wait(S_FETCH);
        push_plain(S_DECODE);
        case (cls)
            0: begin o = 7'b0000011; push_plain(S_MEMADR); push_wait(S_MEMREAD);
                     push_plain(S_MEMWB); end
            1: begin o = 7'b0100011; push_plain(S_MEMADR); push_wait(S_MEMWRITE); end
            2: begin o = 7'b0110011; push_plain(S_EXECR); push_plain(S_ALUWB); end
            3: begin o = 7'b0010011; push_plain(S_EXECI); push_plain(S_ALUWB); end
            4: begin o = 7'b1100011; push_plain(S_BEQ); end
            5: begin o = 7'b1101111; push_plain(S_JAL); push_plain(S_ALUWB); end
            default: begin
                do o = 7'($urandom); while (is_legal(o));
            end
        endcase
        op = o;
        foreach (st_q[i]) step(st_q[i], rdy_q[i]);
    endtask

    initial begin
        rst = 1'b1;
        op = 7'b1100011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b1;
        mem_ready = 1'b1;
        #12;
        check_now("reset", S_FETCH, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Legal classes first so illegal stickiness is exercised afterwards
        for (int i = 0; i < 12; i++) run_instr(i % 6);
        for (int i = 0; i < 140; i++) run_instr(i % 7);

        // Reset asserted mid-store with the write strobe high
        op = 7'b0100011;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b1);
        step(S_MEMADR, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        check_now("store_pre_reset", S_MEMWRITE, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        ill_model = 1'b0;
        check_now("mid_reset", S_FETCH, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
